// File: rtl/cpu_pkg.sv
// Shared types and constants for the 16-bit pipeline: fetch FSM states, the NOP encoding and the IF/ID record.
// Pure declarations, no logic and no flow control.
package cpu_pkg;

   localparam int CPU_PC_W    = 16;
   localparam int CPU_INSTR_W = 16;
   localparam int PC_STEP_DEF = 2;

   localparam logic [CPU_INSTR_W-1:0] NOP_INSTR = 16'h0000;

   typedef enum logic [1:0] {
      FETCH   = 2'd0,
      HOLD    = 2'd1,
      DISCARD = 2'd2,
      HALTED  = 2'd3
   } fetch_state_t;

   typedef struct packed {
      logic [CPU_PC_W-1:0]    pc;
      logic [CPU_INSTR_W-1:0] instr;
      logic                   valid;
   } ifid_t;

endpackage

// File: rtl/fetch_skid_reg.sv
// One-entry hold register for a fetched {pc, instr} pair; load wins over clear. Latency: one cycle.
// Backpressure: none of its own; the owner decides when to load and when to drain.
module fetch_skid_reg #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic         clear,
   input  logic [W-1:0] load_dat,
   output logic [W-1:0] dat,
   output logic         vld
);

   always_ff @(posedge clk) begin
      if (rst) begin
         vld <= 1'b0;
         dat <= '0;
      end else if (load) begin
         vld <= 1'b1;
         dat <= load_dat;
      end else if (clear) begin
         vld <= 1'b0;
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues imem requests and writes IF/ID. Latency: ack in cycle N is in IF/ID after edge N.
// Backpressure: stall holds PC and IF/ID; an ack that lands during a stall parks in the skid register.
module fetch_stage
   import cpu_pkg::*;
#(
   parameter int              PC_W     = 16,
   parameter int              INSTR_W  = 16,
   parameter logic [PC_W-1:0] RESET_PC = '0,
   parameter int              PC_STEP  = PC_STEP_DEF
) (
   input  logic               clk,
   input  logic               rst,
   output logic               imem_req,
   output logic [PC_W-1:0]    imem_addr,
   input  logic [INSTR_W-1:0] imem_rdata,
   input  logic               imem_ready,
   input  logic               stall,
   input  logic               flush,
   input  logic               redirect,
   input  logic [PC_W-1:0]    redirect_pc,
   input  logic               halt,
   output logic [PC_W-1:0]    pc,
   output logic [PC_W-1:0]    ifid_pc,
   output logic [INSTR_W-1:0] ifid_instr,
   output logic               ifid_valid,
   output logic               halted
);

   fetch_state_t state, state_nxt;

   logic [PC_W-1:0]    pc_q, pc_nxt, pc_inc;
   logic [PC_W-1:0]    pend_pc, pend_pc_nxt;
   logic               pend_halt, pend_halt_nxt;
   logic               ack;
   logic               skid_load, skid_clear, skid_vld;
   logic [PC_W-1:0]    skid_pc;
   logic [INSTR_W-1:0] skid_instr;
   logic               new_vld;
   logic [PC_W-1:0]    new_pc;
   logic [INSTR_W-1:0] new_instr;
   logic               enter_halt;

   // DISCARD keeps the request up at the original pc so the address stays stable until the ack.
   assign imem_req  = (state == FETCH) || (state == DISCARD);
   assign imem_addr = pc_q;
   assign ack       = imem_req & imem_ready;
   assign pc_inc    = pc_q + PC_W'(PC_STEP);
   assign pc        = pc_q;
   assign halted    = (state == HALTED);

   fetch_skid_reg #(
      .W(PC_W + INSTR_W)
   ) u_skid (
      .clk      (clk),
      .rst      (rst),
      .load     (skid_load),
      .clear    (skid_clear),
      .load_dat ({pc_q, imem_rdata}),
      .dat      ({skid_pc, skid_instr}),
      .vld      (skid_vld)
   );

   always_comb begin
      state_nxt     = state;
      pc_nxt        = pc_q;
      pend_pc_nxt   = pend_pc;
      pend_halt_nxt = pend_halt;
      skid_load     = 1'b0;
      skid_clear    = 1'b0;
      new_vld       = 1'b0;
      case (state)
         FETCH: begin
            if (halt) begin
               if (ack) begin
                  state_nxt = HALTED;
               end else begin
                  pend_halt_nxt = 1'b1;
                  state_nxt     = DISCARD;
               end
            end else if (redirect) begin
               if (ack) begin
                  pc_nxt = redirect_pc;
               end else begin
                  pend_pc_nxt = redirect_pc;
                  state_nxt   = DISCARD;
               end
            end else if (ack) begin
               pc_nxt = pc_inc;
               if (stall) begin
                  skid_load = 1'b1;
                  state_nxt = HOLD;
               end else begin
                  new_vld = 1'b1;
               end
            end
         end
         HOLD: begin
            if (halt) begin
               skid_clear = 1'b1;
               state_nxt  = HALTED;
            end else if (redirect) begin
               skid_clear = 1'b1;
               pc_nxt     = redirect_pc;
               state_nxt  = FETCH;
            end else if (!stall) begin
               skid_clear = 1'b1;
               new_vld    = skid_vld;
               state_nxt  = FETCH;
            end
         end
         DISCARD: begin
            if (halt)     pend_halt_nxt = 1'b1;
            if (redirect) pend_pc_nxt   = redirect_pc;
            if (ack) begin
               if (halt || pend_halt) begin
                  state_nxt = HALTED;
               end else begin
                  pc_nxt    = redirect ? redirect_pc : pend_pc;
                  state_nxt = FETCH;
               end
            end
         end
         HALTED: begin
            state_nxt = HALTED;
         end
         default: begin
            state_nxt = FETCH;
         end
      endcase
   end

   assign enter_halt = (state != HALTED) && (state_nxt == HALTED);
   assign new_pc     = (state == HOLD) ? skid_pc    : pc_q;
   assign new_instr  = (state == HOLD) ? skid_instr : imem_rdata;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= FETCH;
         pc_q      <= RESET_PC;
         pend_pc   <= '0;
         pend_halt <= 1'b0;
      end else begin
         state     <= state_nxt;
         pc_q      <= pc_nxt;
         pend_pc   <= pend_pc_nxt;
         pend_halt <= pend_halt_nxt;
      end
   end

   // IF/ID: bubble on halt entry or flush, hold on stall, otherwise take the new instruction or a bubble.
   always_ff @(posedge clk) begin
      if (rst) begin
         ifid_pc    <= '0;
         ifid_instr <= NOP_INSTR;
         ifid_valid <= 1'b0;
      end else if (state != HALTED) begin
         if (enter_halt || flush) begin
            ifid_pc    <= '0;
            ifid_instr <= NOP_INSTR;
            ifid_valid <= 1'b0;
         end else if (!stall) begin
            if (new_vld) begin
               ifid_pc    <= new_pc;
               ifid_instr <= new_instr;
               ifid_valid <= 1'b1;
            end else begin
               ifid_pc    <= '0;
               ifid_instr <= NOP_INSTR;
               ifid_valid <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios then random traffic against a queue-based reference model.
module tb_fetch_stage;
   import cpu_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic [15:0] imem_rdata = 16'h0;
   logic        imem_ready = 1'b0;
   logic        stall = 1'b0;
   logic        flush = 1'b0;
   logic        redirect = 1'b0;
   logic [15:0] redirect_pc = 16'h0;
   logic        halt = 1'b0;
   logic [15:0] pc;
   logic [15:0] ifid_pc;
   logic [15:0] ifid_instr;
   logic        ifid_valid;
   logic        halted;

   int checks = 0;
   int errors = 0;

   localparam ifid_t BUBBLE = '{pc: 16'h0, instr: NOP_INSTR, valid: 1'b0};

   // Reference model: architectural view of the fetch stage.
   logic [15:0] m_pc;
   logic [15:0] m_pend_pc;
   bit          m_halted;
   bit          m_pend_halt;
   bit          m_dropping;
   ifid_t       m_ifid;
   ifid_t       m_skid_q[$];

   fetch_stage dut (
      .clk         (clk),
      .rst         (rst),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_rdata  (imem_rdata),
      .imem_ready  (imem_ready),
      .stall       (stall),
      .flush       (flush),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .halt        (halt),
      .pc          (pc),
      .ifid_pc     (ifid_pc),
      .ifid_instr  (ifid_instr),
      .ifid_valid  (ifid_valid),
      .halted      (halted)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic model_step();
      bit    ack;
      bit    got_new;
      bit    to_halt;
      ifid_t newi;
      if (rst) begin
         m_pc        = 16'h0000;
         m_pend_pc   = 16'h0000;
         m_halted    = 1'b0;
         m_pend_halt = 1'b0;
         m_dropping  = 1'b0;
         m_ifid      = BUBBLE;
         m_skid_q.delete();
         return;
      end
      if (m_halted) return;
      got_new = 1'b0;
      to_halt = 1'b0;
      newi    = BUBBLE;
      ack     = (m_skid_q.size() == 0) && imem_ready;
      if (m_skid_q.size() != 0) begin
         if (halt) begin
            m_skid_q.delete();
            to_halt = 1'b1;
         end else if (redirect) begin
            m_skid_q.delete();
            m_pc = redirect_pc;
         end else if (!stall) begin
            newi    = m_skid_q.pop_front();
            got_new = 1'b1;
         end
      end else if (m_dropping) begin
         if (halt)     m_pend_halt = 1'b1;
         if (redirect) m_pend_pc   = redirect_pc;
         if (ack) begin
            m_dropping = 1'b0;
            if (m_pend_halt) to_halt = 1'b1;
            else             m_pc    = m_pend_pc;
         end
      end else begin
         if (halt) begin
            if (ack) to_halt = 1'b1;
            else begin
               m_pend_halt = 1'b1;
               m_dropping  = 1'b1;
            end
         end else if (redirect) begin
            if (ack) m_pc = redirect_pc;
            else begin
               m_pend_pc  = redirect_pc;
               m_dropping = 1'b1;
            end
         end else if (ack) begin
            newi = '{pc: m_pc, instr: imem_rdata, valid: 1'b1};
            m_pc = m_pc + 16'd2;
            if (stall) m_skid_q.push_back(newi);
            else       got_new = 1'b1;
         end
      end
      if (to_halt) begin
         m_halted = 1'b1;
         m_ifid   = BUBBLE;
      end else if (flush) begin
         m_ifid = BUBBLE;
      end else if (!stall) begin
         m_ifid = got_new ? newi : BUBBLE;
      end
   endtask

   task automatic cycle();
      model_step();
      @(posedge clk);
      #1;
      chk("imem_req",   imem_req,   !m_halted && (m_skid_q.size() == 0));
      chk("imem_addr",  imem_addr,  m_pc);
      chk("pc",         pc,         m_pc);
      chk("halted",     halted,     m_halted);
      chk("ifid_valid", ifid_valid, m_ifid.valid);
      chk("ifid_pc",    ifid_pc,    m_ifid.pc);
      chk("ifid_instr", ifid_instr, m_ifid.instr);
   endtask

   task automatic idle_inputs();
      stall    = 1'b0;
      flush    = 1'b0;
      redirect = 1'b0;
      halt     = 1'b0;
   endtask

   initial begin
      logic [15:0] data1 [4];
      int halt_cnt;
      data1[0] = 16'h1111; data1[1] = 16'h2222; data1[2] = 16'h3333; data1[3] = 16'h4444;

      // Reset state
      rst = 1'b1;
      cycle();
      cycle();
      chk("rst_pc", pc, 16'h0000);
      chk("rst_valid", ifid_valid, 1'b0);
      chk("rst_halted", halted, 1'b0);
      chk("rst_req", imem_req, 1'b1);

      // Back-to-back fetch, one instruction per cycle
      rst = 1'b0;
      imem_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         imem_rdata = data1[k];
         cycle();
         chk("seq_ifid_pc", ifid_pc, 16'(2 * k));
         chk("seq_ifid_instr", ifid_instr, data1[k]);
         chk("seq_valid", ifid_valid, 1'b1);
      end
      chk("seq_pc_end", pc, 16'h0008);

      // Stall in the ack cycle for pc=4
      rst = 1'b1; cycle(); rst = 1'b0;
      imem_ready = 1'b1;
      imem_rdata = 16'h1111; cycle();
      imem_rdata = 16'h2222; cycle();
      imem_rdata = 16'hABCD; stall = 1'b1;
      for (int k = 0; k < 3; k++) begin
         cycle();
         chk("stall_hold_pc", ifid_pc, 16'h0002);
         chk("stall_hold_instr", ifid_instr, 16'h2222);
      end
      stall = 1'b0; imem_ready = 1'b0;
      cycle();
      chk("unstall_pc", ifid_pc, 16'h0004);
      chk("unstall_instr", ifid_instr, 16'hABCD);
      chk("unstall_valid", ifid_valid, 1'b1);
      chk("unstall_addr", imem_addr, 16'h0006);

      // Redirect while pc=6 is outstanding; late data must be discarded
      redirect = 1'b1; redirect_pc = 16'h0040;
      cycle();
      redirect = 1'b0;
      chk("disc_addr_stable", imem_addr, 16'h0006);
      cycle();
      imem_ready = 1'b1; imem_rdata = 16'hDEAD;
      cycle();
      chk("disc_dropped_valid", ifid_valid, 1'b0);
      chk("disc_next_addr", imem_addr, 16'h0040);
      imem_rdata = 16'h5555;
      cycle();
      chk("disc_target_pc", ifid_pc, 16'h0040);
      chk("disc_target_instr", ifid_instr, 16'h5555);

      // Redirect + flush with an ack
      imem_rdata = 16'h7777; redirect = 1'b1; flush = 1'b1; redirect_pc = 16'h0100;
      cycle();
      idle_inputs();
      chk("rf_valid", ifid_valid, 1'b0);
      chk("rf_instr", ifid_instr, 16'h0000);
      chk("rf_addr", imem_addr, 16'h0100);

      // Halt with a fetch outstanding
      imem_ready = 1'b0; halt = 1'b1;
      cycle();
      halt = 1'b0;
      chk("halt_wait", halted, 1'b0);
      imem_ready = 1'b1;
      cycle();
      chk("halt_set", halted, 1'b1);
      chk("halt_req", imem_req, 1'b0);
      for (int k = 0; k < 10; k++) begin
         redirect = k[0]; redirect_pc = 16'h0200; stall = k[1]; flush = k[2];
         cycle();
         chk("halt_pc_frozen", pc, 16'h0100);
      end
      idle_inputs();
      rst = 1'b1; cycle(); rst = 1'b0;
      chk("halt_rst_pc", pc, 16'h0000);
      chk("halt_rst_halted", halted, 1'b0);

      // PC wrap at 16'hFFFE
      imem_ready = 1'b1; redirect = 1'b1; redirect_pc = 16'hFFFE;
      cycle();
      redirect = 1'b0; imem_rdata = 16'h9999;
      cycle();
      chk("wrap_ifid_pc", ifid_pc, 16'hFFFE);
      chk("wrap_addr", imem_addr, 16'h0000);

      // Random traffic
      halt_cnt = 0;
      for (int n = 0; n < 3000; n++) begin
         rst         = (halt_cnt > 6) || ($urandom_range(0, 499) == 0);
         imem_ready  = ($urandom_range(0, 3) != 0);
         imem_rdata  = 16'($urandom);
         stall       = ($urandom_range(0, 4) == 0);
         redirect    = ($urandom_range(0, 11) == 0);
         redirect_pc = 16'($urandom) & 16'hFFFE;
         flush       = redirect & 1'($urandom);
         halt        = ($urandom_range(0, 149) == 0);
         cycle();
         halt_cnt = m_halted ? halt_cnt + 1 : 0;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
